// File: rtl/pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen
//
// Purpose
//   Drives one half-bridge leg from the free-running gate-driver timer count.
//   The count is compared against a double-buffered duty value. The result
//   then passes through a five-state dead-time FSM. The high-side and
//   low-side gate enables that come out are complementary and are never
//   asserted together.
//
// Parameters
//   N     width of the timer count and of the duty value
//   DT_W  width of dead_time_clks
//
// Ports
//   clk             in   1     system clock
//   reset           in   1     asynchronous, active-high reset
//   cnt             in   N     free-running timer count, wraps 2^N-1 -> 0
//   enable          in   1     1 = run, 0 = both gates off
//   duty_in         in   N     new duty value, in counts
//   duty_wr         in   1     1-clk pulse, loads duty_in into the pending register
//   dead_time_clks  in   DT_W  dead time in clocks (0 behaves as 1)
//   hs_gate         out  1     high-side gate enable (registered)
//   ls_gate         out  1     low-side gate enable (registered)
//   period_tick     out  1     1-clk pulse, one cycle after cnt == 2^N-1
//   state           out  3     FSM state, for debug
//   fault           in   1     [FAULT_LATCH_EN] asynchronous fault from the driver
//   fault_clr       in   1     [FAULT_LATCH_EN] 1-clk clear pulse
//   fault_latched   out  1     [FAULT_LATCH_EN] sticky fault flag
//
// Configuration
//   FAULT_LATCH_EN  When defined, a two-flop synchronised fault input latches
//                   a sticky flag and holds the FSM in OFF until it is
//                   cleared. When undefined, the fault ports do not exist.
// -----------------------------------------------------------------------------
module pwm_deadtime_gen #(
    parameter int N    = 13,
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    cnt,
    input  logic            enable,
    input  logic [N-1:0]    duty_in,
    input  logic            duty_wr,
    input  logic [DT_W-1:0] dead_time_clks,
`ifdef FAULT_LATCH_EN
    input  logic            fault,
    input  logic            fault_clr,
    output logic            fault_latched,
`endif
    output logic            hs_gate,
    output logic            ls_gate,
    output logic            period_tick,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DT_HS = 3'd1,
        ST_HS_ON = 3'd2,
        ST_DT_LS = 3'd3,
        ST_LS_ON = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and combinational nets
    // -------------------------------------------------------------------------
    logic [N-1:0]    r_duty_pend;
    logic [N-1:0]    r_duty_act;
    logic            r_raw_q;
    logic [DT_W-1:0] r_dt_cnt;
    state_t          r_state;
    logic            r_hs_gate;
    logic            r_ls_gate;
    logic            r_period_tick;

    logic            w_wrap;
    logic            w_raw;
    logic [DT_W-1:0] w_dt_load;
    logic            w_fault_block;
    logic            w_force_off;
    state_t          w_state_nxt;
    logic [DT_W-1:0] w_dt_cnt_nxt;

    // -------------------------------------------------------------------------
    // Duty double buffer and comparator
    // -------------------------------------------------------------------------
    assign w_wrap = (cnt == {N{1'b1}});
    assign w_raw  = (cnt < r_duty_act);

    // NOTE: sequential state uses non-blocking assignments. Because of this,
    // r_duty_act picks up the *old* r_duty_pend when duty_wr and the wrap
    // happen in the same cycle, and the new value waits for the next wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty_pend   <= '0;
            r_duty_act    <= '0;
            r_raw_q       <= 1'b0;
            r_period_tick <= 1'b0;
        end else begin
            if (duty_wr) begin
                r_duty_pend <= duty_in;
            end
            if (w_wrap) begin
                r_duty_act <= r_duty_pend;
            end
            r_raw_q       <= w_raw;
            r_period_tick <= w_wrap;
        end
    end

    // -------------------------------------------------------------------------
    // Optional fault latch
    // -------------------------------------------------------------------------
`ifdef FAULT_LATCH_EN
    logic r_fault_meta;
    logic r_fault_sync;
    logic r_fault_latched;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault_meta    <= 1'b0;
            r_fault_sync    <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_fault_meta <= fault;
            r_fault_sync <= r_fault_meta;
            // A clear request is honoured only once the synchronised fault
            // has gone away; otherwise the fault keeps the flag set.
            if (r_fault_sync) begin
                r_fault_latched <= 1'b1;
            end else if (fault_clr) begin
                r_fault_latched <= 1'b0;
            end
        end
    end

    // The first synchronised fault cycle already forces OFF, before the
    // sticky flag itself is visible.
    assign w_fault_block = r_fault_sync | r_fault_latched;
    assign fault_latched = r_fault_latched;
`else
    assign w_fault_block = 1'b0;
`endif

    assign w_force_off = !enable || w_fault_block;

    // Dead-time reload value. A setting of 0 behaves as 1 clock. The value is
    // only sampled here, on entry to a DT state.
    assign w_dt_load = (dead_time_clks == '0) ? '0 : dead_time_clks - DT_W'(1);

    // -------------------------------------------------------------------------
    // Dead-time FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven in this always_comb block is given a default
    // first, so no path through it can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_dt_cnt_nxt = r_dt_cnt;

        if (w_force_off) begin
            w_state_nxt = ST_OFF;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    w_state_nxt  = r_raw_q ? ST_DT_HS : ST_DT_LS;
                    w_dt_cnt_nxt = w_dt_load;
                end
                ST_DT_HS: begin
                    if (!r_raw_q) begin
                        // The high request ended before the dead time ran out,
                        // so the glitch is swallowed and we turn around.
                        w_state_nxt  = ST_DT_LS;
                        w_dt_cnt_nxt = w_dt_load;
                    end else if (r_dt_cnt == '0) begin
                        w_state_nxt = ST_HS_ON;
                    end else begin
                        w_dt_cnt_nxt = r_dt_cnt - DT_W'(1);
                    end
                end
                ST_HS_ON: begin
                    if (!r_raw_q) begin
                        w_state_nxt  = ST_DT_LS;
                        w_dt_cnt_nxt = w_dt_load;
                    end
                end
                ST_DT_LS: begin
                    if (r_raw_q) begin
                        w_state_nxt  = ST_DT_HS;
                        w_dt_cnt_nxt = w_dt_load;
                    end else if (r_dt_cnt == '0) begin
                        w_state_nxt = ST_LS_ON;
                    end else begin
                        w_dt_cnt_nxt = r_dt_cnt - DT_W'(1);
                    end
                end
                ST_LS_ON: begin
                    if (r_raw_q) begin
                        w_state_nxt  = ST_DT_HS;
                        w_dt_cnt_nxt = w_dt_load;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Dead-time FSM: state register and registered gate decode
    // -------------------------------------------------------------------------
    // The gates are decoded from the next state, so each gate flop always
    // equals (state == *_ON) in the same cycle. Both gates come from one
    // state register, so they can never be high together. The asynchronous
    // reset drops both gates at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_OFF;
            r_dt_cnt  <= '0;
            r_hs_gate <= 1'b0;
            r_ls_gate <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dt_cnt  <= w_dt_cnt_nxt;
            r_hs_gate <= (w_state_nxt == ST_HS_ON);
            r_ls_gate <= (w_state_nxt == ST_LS_ON);
        end
    end

    assign hs_gate     = r_hs_gate;
    assign ls_gate     = r_ls_gate;
    assign period_tick = r_period_tick;
    assign state       = r_state;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime_gen
//
// Directed bench for pwm_deadtime_gen with N=8. It drives a free-running
// 8-bit count and steps through duty, dead-time, enable, reset and (with
// FAULT_LATCH_EN) fault scenarios. Expected values were worked out by hand
// from the timing rules:
//   - raw_q lags cnt by one clock.
//   - A gate changes one clock after that.
//   - A dead time of D (D >= 1) keeps both gates low for D clocks.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime_gen;

    localparam int N    = 8;
    localparam int DT_W = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    cnt;
    logic            enable;
    logic [N-1:0]    duty_in;
    logic            duty_wr;
    logic [DT_W-1:0] dead_time_clks;
    logic            hs_gate;
    logic            ls_gate;
    logic            period_tick;
    logic [2:0]      state;
`ifdef FAULT_LATCH_EN
    logic            fault;
    logic            fault_clr;
    logic            fault_latched;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Per-window statistics, sampled once per clock after the edge.
    int n_hs, n_ls, n_both, n_tick;
    int n_both_total = 0;

    pwm_deadtime_gen #(.N(N), .DT_W(DT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cnt            (cnt),
        .enable         (enable),
        .duty_in        (duty_in),
        .duty_wr        (duty_wr),
        .dead_time_clks (dead_time_clks),
`ifdef FAULT_LATCH_EN
        .fault          (fault),
        .fault_clr      (fault_clr),
        .fault_latched  (fault_latched),
`endif
        .hs_gate        (hs_gate),
        .ls_gate        (ls_gate),
        .period_tick    (period_tick),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock: wait for the edge, settle, end any duty_wr pulse, advance
    // the count, and accumulate the output statistics for that edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        duty_wr = 1'b0;
        cnt     = cnt + 8'd1;
        n_hs   += int'(hs_gate);
        n_ls   += int'(ls_gate);
        n_tick += int'(period_tick);
        if (hs_gate && ls_gate) begin
            n_both++;
            n_both_total++;
        end
    endtask

    // Advance until the count applied for the next edge equals v.
    task automatic run_to(input logic [N-1:0] v);
        int k = 0;
        while (cnt !== v && k < 600) begin
            cyc();
            k++;
        end
        if (cnt !== v) begin
            n_fail++;
            $error("FAIL run_to: count %0d never reached %0d", cnt, v);
        end
    endtask

    task automatic clear_stats();
        n_hs   = 0;
        n_ls   = 0;
        n_both = 0;
        n_tick = 0;
    endtask

    task automatic write_duty(input logic [N-1:0] d);
        duty_in = d;
        duty_wr = 1'b1;
        cyc();
    endtask

    // Load a new duty, let it reach duty_act at the wrap, let one full period
    // flush the transient, then sample a 256-clock window.
    task automatic settle_and_measure(input logic [N-1:0] d);
        write_duty(d);
        run_to(8'd0);
        repeat (256) cyc();
        clear_stats();
        repeat (256) cyc();
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        cnt            = '0;
        duty_in        = '0;
        duty_wr        = 1'b0;
        dead_time_clks = 8'd4;
`ifdef FAULT_LATCH_EN
        fault          = 1'b0;
        fault_clr      = 1'b0;
`endif
        clear_stats();

        // ---- Reset state ----
        repeat (3) cyc();
        check("rst_state", 32'(state), 0);
        check("rst_hs", 32'(hs_gate), 0);
        check("rst_ls", 32'(ls_gate), 0);
        check("rst_tick", 32'(period_tick), 0);
`ifdef FAULT_LATCH_EN
        check("rst_fault_latched", 32'(fault_latched), 0);
`endif
        reset = 1'b0;

        // ---- 1. duty 64, dead time 4, three periods ----
        write_duty(8'd64);
        enable = 1'b1;
        run_to(8'd0);
        repeat (256) cyc();
        for (int p = 0; p < 3; p++) begin
            clear_stats();
            repeat (256) cyc();
            check($sformatf("t1_hs_clks_p%0d", p), 32'(n_hs), 60);
            check($sformatf("t1_ls_clks_p%0d", p), 32'(n_ls), 188);
            check($sformatf("t1_overlap_p%0d", p), 32'(n_both), 0);
            check($sformatf("t1_tick_p%0d", p), 32'(n_tick), 1);
        end

        // Edge timing: hs falls 2 clocks after cnt==64, ls rises 4 clocks
        // later. dead_time_clks is changed mid-dead-time and must not matter.
        run_to(8'd64);
        cyc();
        check("t1_hs_at_cmp", 32'(hs_gate), 1);
        cyc();
        check("t1_hs_fall", 32'(hs_gate), 0);
        check("t1_state_dt_ls", 32'(state), 3);
        dead_time_clks = 8'd0;
        repeat (3) cyc();
        check("t1_dt_hold_state", 32'(state), 3);
        check("t1_dt_hold_ls", 32'(ls_gate), 0);
        cyc();
        check("t1_ls_rise", 32'(ls_gate), 1);
        check("t1_state_ls_on", 32'(state), 4);
        dead_time_clks = 8'd4;

        // ---- 2. write 128 at cnt=10; the old duty holds until the wrap ----
        run_to(8'd10);
        write_duty(8'd128);
        run_to(8'd64);
        check("t2_old_duty_hs_on", 32'(hs_gate), 1);
        run_to(8'd66);
        check("t2_old_duty_hs_off", 32'(hs_gate), 0);
        check("t2_old_duty_state", 32'(state), 3);
        run_to(8'd0);
        clear_stats();
        repeat (256) cyc();
        check("t2_hs_clks", 32'(n_hs), 124);
        check("t2_ls_clks", 32'(n_ls), 124);
        check("t2_tick", 32'(n_tick), 1);

        // duty_wr in the same cycle as the wrap: 128 is used for one more
        // period, then 32 takes over.
        run_to(8'd255);
        write_duty(8'd32);
        run_to(8'd41);
        check("t2_wrap_wr_old", 32'(hs_gate), 1);
        run_to(8'd0);
        run_to(8'd41);
        check("t2_wrap_wr_new_hs", 32'(hs_gate), 0);
        check("t2_wrap_wr_new_ls", 32'(ls_gate), 1);
        check("t2_wrap_wr_new_state", 32'(state), 4);

        // ---- 3. pulses shorter than the dead time are suppressed ----
        settle_and_measure(8'd254);
        check("t3_short_low_hs", 32'(n_hs), 250);
        check("t3_short_low_ls", 32'(n_ls), 0);
        settle_and_measure(8'd2);
        check("t3_short_high_hs", 32'(n_hs), 0);
        check("t3_short_high_ls", 32'(n_ls), 250);

        // ---- 4. duty 0 and duty 255 ----
        settle_and_measure(8'd0);
        check("t4_duty0_hs", 32'(n_hs), 0);
        check("t4_duty0_ls", 32'(n_ls), 256);
        settle_and_measure(8'd255);
        check("t4_duty255_hs", 32'(n_hs), 251);
        check("t4_duty255_ls", 32'(n_ls), 0);
        check("t4_overlap", 32'(n_both), 0);

        // ---- 5. dead_time_clks = 0 behaves as 1 clock ----
        dead_time_clks = 8'd0;
        write_duty(8'd128);
        run_to(8'd0);
        repeat (256) cyc();
        run_to(8'd128);
        cyc();
        check("t5_hs_at_cmp", 32'(hs_gate), 1);
        cyc();
        check("t5_hs_fall", 32'(hs_gate), 0);
        check("t5_dt1_state", 32'(state), 3);
        cyc();
        check("t5_ls_rise_after_1", 32'(ls_gate), 1);

        // Enable dropped while in HS_ON.
        run_to(8'd50);
        check("t5_hs_on_before_dis", 32'(state), 2);
        enable = 1'b0;
        cyc();
        check("t5_dis_hs", 32'(hs_gate), 0);
        check("t5_dis_ls", 32'(ls_gate), 0);
        check("t5_dis_state", 32'(state), 0);
        repeat (3) cyc();
        check("t5_dis_stays_off", 32'(state), 0);
        enable = 1'b1;
        cyc();
        check("t5_reen_dt_hs", 32'(state), 1);
        cyc();
        check("t5_reen_hs_on", 32'(hs_gate), 1);

        // Reset asserted mid-period, away from any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_rst_hs", 32'(hs_gate), 0);
        check("t5_async_rst_ls", 32'(ls_gate), 0);
        check("t5_async_rst_state", 32'(state), 0);
        check("t5_async_rst_tick", 32'(period_tick), 0);
        repeat (2) cyc();
        reset = 1'b0;
        // duty_act was cleared, so the comparator is low and the FSM goes low side.
        cyc();
        check("t5_post_rst_dt_ls", 32'(state), 3);

`ifdef FAULT_LATCH_EN
        // ---- 6. fault latch ----
        dead_time_clks = 8'd4;
        write_duty(8'd128);
        run_to(8'd0);
        run_to(8'd200);
        check("t6_ls_on_before_fault", 32'(state), 4);
        fault = 1'b1;
        repeat (3) cyc();
        check("t6_fault_hs", 32'(hs_gate), 0);
        check("t6_fault_ls", 32'(ls_gate), 0);
        check("t6_fault_state", 32'(state), 0);
        check("t6_fault_latched", 32'(fault_latched), 1);
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        repeat (2) cyc();
        check("t6_clr_ignored_flag", 32'(fault_latched), 1);
        check("t6_clr_ignored_state", 32'(state), 0);
        fault = 1'b0;
        repeat (3) cyc();
        check("t6_still_off", 32'(state), 0);
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        check("t6_cleared_flag", 32'(fault_latched), 0);
        cyc();
        check("t6_resume_dt_ls", 32'(state), 3);
        repeat (4) cyc();
        check("t6_resume_ls_on", 32'(state), 4);
`endif

        check("no_overlap_whole_run", 32'(n_both_total), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
